// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Pixel stage between the VGA timing controller and the DAC/IO pads.
// Turns the controller's row/column/strobe stream into 12-bit RGB using a
// programmable pattern (solid, colour bars, checkerboard, box overlay).
// The syncs and blank travel through the same two registers as the colour,
// so everything stays aligned.
// Configuration is written over Wishbone into shadow registers. It is copied
// into the active registers only at frame start (v_sync becoming active), so
// a frame is never drawn with a half-updated configuration.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   cyc/stb/we/adr/dat, ack/dout
//                   Wishbone slave (word registers at adr[4:2])
//   row, column     current pixel coordinates
//   display_enable, n_blank, n_sync, h_sync, v_sync
//                   timing strobes from the controller
//   red, green, blue
//                   registered pixel colour
//   de_o, n_blank_o, n_sync_o, h_sync_o, v_sync_o
//                   strobes delayed to line up with the colour
module vga_pattern_gen #(
    parameter logic SYNC_POL    = 1'b0,
    parameter int   CHECK_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    output logic        ack,
    output logic [31:0] dout,
    input  logic [11:0] row,
    input  logic [11:0] column,
    input  logic        display_enable,
    input  logic        n_blank,
    input  logic        n_sync,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        de_o,
    output logic        n_blank_o,
    output logic        n_sync_o,
    output logic        h_sync_o,
    output logic        v_sync_o
);

    // Shadow (bus-visible) configuration
    logic [2:0]  sh_ctrl_r;
    logic [11:0] sh_fg_r;
    logic [11:0] sh_bg_r;
    logic [11:0] sh_x0_r;
    logic [11:0] sh_x1_r;
    logic [11:0] sh_y0_r;
    logic [11:0] sh_y1_r;

    // Active (pixel-visible) configuration
    logic [2:0]  act_ctrl_r;
    logic [11:0] act_fg_r;
    logic [11:0] act_bg_r;
    logic [11:0] act_x0_r;
    logic [11:0] act_x1_r;
    logic [11:0] act_y0_r;
    logic [11:0] act_y1_r;

    logic [15:0] frame_r;
    logic        vs_prev_r;
    logic        frame_start_s;
    logic        req_s;
    logic [31:0] rd_data_s;
    logic [11:0] colour_s;
    logic        in_box_s;

    // First pipeline stage
    logic [11:0] s1_rgb_r;
    logic        s1_de_r;
    logic        s1_nblank_r;
    logic        s1_nsync_r;
    logic        s1_hs_r;
    logic        s1_vs_r;

    // Bits of the bus that no register field uses
    logic        unused_bits_s;
    assign unused_bits_s = ^{adr[31:5], adr[1:0], dat[31:28], dat[15:12]};

    // The request is only seen when no ack is pending, which produces
    // the ack-every-other-cycle behaviour for back-to-back strobes.
    assign req_s = cyc & stb & ~ack;

    // Frame start: v_sync has just entered its active level.
    assign frame_start_s = (v_sync == SYNC_POL) && (vs_prev_r != SYNC_POL);

    // Read mux over the shadow registers and the frame counter
    always_comb begin
        rd_data_s = 32'd0;
        case (adr[4:2])
            3'd0:    rd_data_s = {29'd0, sh_ctrl_r};
            3'd1:    rd_data_s = {20'd0, sh_fg_r};
            3'd2:    rd_data_s = {20'd0, sh_bg_r};
            3'd3:    rd_data_s = {4'd0, sh_x1_r, 4'd0, sh_x0_r};
            3'd4:    rd_data_s = {4'd0, sh_y1_r, 4'd0, sh_y0_r};
            3'd5:    rd_data_s = {16'd0, frame_r};
            default: rd_data_s = 32'd0;
        endcase
    end

    // Wishbone handshake, read data capture and shadow register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            dout      <= 32'd0;
            sh_ctrl_r <= 3'd0;
            sh_fg_r   <= 12'd0;
            sh_bg_r   <= 12'd0;
            sh_x0_r   <= 12'd0;
            sh_x1_r   <= 12'd0;
            sh_y0_r   <= 12'd0;
            sh_y1_r   <= 12'd0;
        end else begin
            ack <= req_s;
            if (req_s && !we) begin
                dout <= rd_data_s;
            end else begin
                dout <= 32'd0;
            end
            if (req_s && we) begin
                case (adr[4:2])
                    3'd0: sh_ctrl_r <= dat[2:0];
                    3'd1: sh_fg_r   <= dat[11:0];
                    3'd2: sh_bg_r   <= dat[11:0];
                    3'd3: begin
                        sh_x0_r <= dat[11:0];
                        sh_x1_r <= dat[27:16];
                    end
                    3'd4: begin
                        sh_y0_r <= dat[11:0];
                        sh_y1_r <= dat[27:16];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame-start detection, shadow-to-active copy and frame counter.
    // The copy takes the shadow values from before any write committing
    // on the same edge, so such a write lands one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_r  <= SYNC_POL;
            frame_r    <= 16'd0;
            act_ctrl_r <= 3'd0;
            act_fg_r   <= 12'd0;
            act_bg_r   <= 12'd0;
            act_x0_r   <= 12'd0;
            act_x1_r   <= 12'd0;
            act_y0_r   <= 12'd0;
            act_y1_r   <= 12'd0;
        end else begin
            vs_prev_r <= v_sync;
            if (frame_start_s) begin
                frame_r    <= frame_r + 16'd1;
                act_ctrl_r <= sh_ctrl_r;
                act_fg_r   <= sh_fg_r;
                act_bg_r   <= sh_bg_r;
                act_x0_r   <= sh_x0_r;
                act_x1_r   <= sh_x1_r;
                act_y0_r   <= sh_y0_r;
                act_y1_r   <= sh_y1_r;
            end
        end
    end

    // Inclusive box hit; a reversed range simply never matches
    assign in_box_s = (column >= act_x0_r) && (column <= act_x1_r) &&
                      (row >= act_y0_r) && (row <= act_y1_r);

    // Pattern selection for the incoming pixel
    always_comb begin
        colour_s = act_bg_r;
        case (act_ctrl_r[1:0])
            2'd0: colour_s = act_bg_r;
            2'd1: colour_s = {{4{column[9]}}, {4{column[8]}}, {4{column[7]}}};
            2'd2: colour_s = (row[CHECK_SHIFT] ^ column[CHECK_SHIFT]) ? act_fg_r : act_bg_r;
            2'd3: colour_s = in_box_s ? act_fg_r : act_bg_r;
            default: colour_s = act_bg_r;
        endcase
        if (!act_ctrl_r[2]) begin
            colour_s = act_bg_r;
        end else begin
            colour_s = colour_s;
        end
        if (!display_enable || !n_blank) begin
            colour_s = 12'd0;
        end else begin
            colour_s = colour_s;
        end
    end

    // Pipeline stage 1: colour and strobes for the sampled pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rgb_r    <= 12'd0;
            s1_de_r     <= 1'b0;
            s1_nblank_r <= 1'b0;
            s1_nsync_r  <= 1'b1;
            s1_hs_r     <= ~SYNC_POL;
            s1_vs_r     <= ~SYNC_POL;
        end else begin
            s1_rgb_r    <= colour_s;
            s1_de_r     <= display_enable;
            s1_nblank_r <= n_blank;
            s1_nsync_r  <= n_sync;
            s1_hs_r     <= h_sync;
            s1_vs_r     <= v_sync;
        end
    end

    // Pipeline stage 2: registered outputs to the pads
    always_ff @(posedge clk) begin
        if (rst) begin
            red       <= 4'd0;
            green     <= 4'd0;
            blue      <= 4'd0;
            de_o      <= 1'b0;
            n_blank_o <= 1'b0;
            n_sync_o  <= 1'b1;
            h_sync_o  <= ~SYNC_POL;
            v_sync_o  <= ~SYNC_POL;
        end else begin
            red       <= s1_rgb_r[11:8];
            green     <= s1_rgb_r[7:4];
            blue      <= s1_rgb_r[3:0];
            de_o      <= s1_de_r;
            n_blank_o <= s1_nblank_r;
            n_sync_o  <= s1_nsync_r;
            h_sync_o  <= s1_hs_r;
            v_sync_o  <= s1_vs_r;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen (SYNC_POL = 0, CHECK_SHIFT = 5).
// A cycle-level reference model (register words, frame count, a two-entry
// output queue) predicts every output after every clock edge; directed
// scenarios add checks against hand-computed constants.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] dout;
    logic [11:0] row, column;
    logic        display_enable, n_blank, n_sync, h_sync, v_sync;
    logic [3:0]  red, green, blue;
    logic        de_o, n_blank_o, n_sync_o, h_sync_o, v_sync_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: register words as read back, masked per field
    logic [31:0] m_sh[5];
    logic [31:0] m_act[5];
    logic [15:0] m_frame;
    logic        m_ack;
    logic [31:0] m_dout;
    logic        m_vs_prev;
    logic [16:0] m_q[2];   // {rgb, de, n_blank, n_sync, h_sync, v_sync}; [1] is on the pins

    localparam logic [16:0] RESET_OUT = {12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    vga_pattern_gen #(.SYNC_POL(1'b0), .CHECK_SHIFT(5)) dut (
        .clk(clk), .rst(rst),
        .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat(dat),
        .ack(ack), .dout(dout),
        .row(row), .column(column),
        .display_enable(display_enable), .n_blank(n_blank), .n_sync(n_sync),
        .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .de_o(de_o), .n_blank_o(n_blank_o), .n_sync_o(n_sync_o),
        .h_sync_o(h_sync_o), .v_sync_o(v_sync_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] field_mask(int idx);
        case (idx)
            0:       return 32'h0000_0007;
            1, 2:    return 32'h0000_0FFF;
            default: return 32'h0FFF_0FFF;
        endcase
    endfunction

    // Expected colour from the pattern rules applied to the active words
    function automatic logic [11:0] exp_pix(int r, int c, logic de, logic nb);
        int mode, idx, x0, x1, y0, y1;
        logic [11:0] fg, bg, res;
        mode = int'(m_act[0] & 32'd3);
        fg = m_act[1][11:0];
        bg = m_act[2][11:0];
        x0 = int'(m_act[3] & 32'hFFF);
        x1 = int'((m_act[3] >> 16) & 32'hFFF);
        y0 = int'(m_act[4] & 32'hFFF);
        y1 = int'((m_act[4] >> 16) & 32'hFFF);
        res = bg;
        if (mode == 1) begin
            idx = (c / 128) % 8;
            res = {(idx >= 4) ? 4'hF : 4'h0, ((idx / 2) % 2 == 1) ? 4'hF : 4'h0,
                   (idx % 2 == 1) ? 4'hF : 4'h0};
        end else if (mode == 2) begin
            res = ((((r / 32) + (c / 32)) % 2) == 1) ? fg : bg;
        end else if (mode == 3) begin
            res = (c >= x0 && c <= x1 && r >= y0 && r <= y1) ? fg : bg;
        end
        if ((m_act[0] & 32'd4) == 32'd0) res = bg;
        if (!de || !nb) res = 12'h000;
        return res;
    endfunction

    // Advance the model over one edge using the inputs now on the pins
    task automatic model_edge();
        logic req, fs;
        logic [31:0] rd;
        int widx;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_sh[i] = 32'd0;
                m_act[i] = 32'd0;
            end
            m_frame = 16'd0;
            m_ack = 1'b0;
            m_dout = 32'd0;
            m_vs_prev = 1'b0;
            m_q[0] = RESET_OUT;
            m_q[1] = RESET_OUT;
        end else begin
            m_q[1] = m_q[0];
            m_q[0] = {exp_pix(int'(row), int'(column), display_enable, n_blank),
                      display_enable, n_blank, n_sync, h_sync, v_sync};
            req = cyc && stb && !m_ack;
            widx = int'(adr[4:2]);
            rd = (widx < 5) ? m_sh[widx] : ((widx == 5) ? {16'd0, m_frame} : 32'd0);
            fs = (v_sync == 1'b0) && (m_vs_prev == 1'b1);
            if (fs) begin
                for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
                m_frame = m_frame + 16'd1;
            end
            if (req && we && widx < 5) m_sh[widx] = dat & field_mask(widx);
            m_vs_prev = v_sync;
            m_ack = req;
            m_dout = (req && !we) ? rd : 32'd0;
        end
    endtask

    // One clock: model, edge, then compare everything on the falling edge
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_val("rgb", {20'd0, red, green, blue}, {20'd0, m_q[1][16:5]});
        check_val("strobes", {27'd0, de_o, n_blank_o, n_sync_o, h_sync_o, v_sync_o},
                  {27'd0, m_q[1][4:0]});
        check_val("ack", {31'd0, ack}, {31'd0, m_ack});
        check_val("dout", dout, m_dout);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
        step();
        check_val("wr_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        step();
        check_val("rd_ack", {31'd0, ack}, 32'd1);
        d = dout;
        cyc = 1'b0; stb = 1'b0;
        step();
    endtask

    task automatic frame_pulse();
        v_sync = 1'b0;
        step();
        v_sync = 1'b1;
        step();
    endtask

    task automatic show_pixel(input int r, input int c, input logic [11:0] exp, input string tag);
        row = 12'(r); column = 12'(c); display_enable = 1'b1; n_blank = 1'b1;
        step();
        step();
        check_val(tag, {20'd0, red, green, blue}, {20'd0, exp});
    endtask

    initial begin
        logic [31:0] rdv, f0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat = 32'd0;
        row = 12'd0; column = 12'd0; display_enable = 1'b0; n_blank = 1'b0;
        n_sync = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        step();
        rst = 1'b0;
        check_val("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        check_val("reset_hs", {31'd0, h_sync_o}, 32'd1);
        check_val("reset_vs", {31'd0, v_sync_o}, 32'd1);

        // Register access
        wb_write(32'h04, 32'h0000_0ABC);
        wb_read(32'h04, rdv);  check_val("fg_read", rdv, 32'h0000_0ABC);
        wb_read(32'h14, rdv);  check_val("frame_init", rdv, 32'd0);
        wb_read(32'h18, rdv);  check_val("unmapped", rdv, 32'd0);
        wb_write(32'h0C, 32'hFFFF_FFFF);
        wb_read(32'h0C, rdv);  check_val("boxx_mask", rdv, 32'h0FFF_0FFF);

        // Shadowing: CTRL takes effect only after frame start
        wb_write(32'h08, 32'h123);
        frame_pulse();
        wb_write(32'h00, 32'h5);
        show_pixel(10, 12'h180, 12'h123, "shadow_hold");
        frame_pulse();
        show_pixel(10, 12'h180, 12'h0FF, "bars_idx3");

        // Checkerboard
        wb_write(32'h04, 32'hF00);
        wb_write(32'h00, 32'h6);
        frame_pulse();
        show_pixel(0, 32, 12'hF00, "checker_fg");
        show_pixel(32, 32, 12'h123, "checker_bg");

        // Box overlay
        wb_write(32'h08, 32'h00F);
        wb_write(32'h0C, (32'd200 << 16) | 32'd100);
        wb_write(32'h10, (32'd60 << 16) | 32'd50);
        wb_write(32'h00, 32'h7);
        frame_pulse();
        show_pixel(50, 100, 12'hF00, "box_in");
        show_pixel(61, 150, 12'h00F, "box_out");
        show_pixel(60, 200, 12'hF00, "box_corner");
        show_pixel(50, 201, 12'h00F, "box_right");
        wb_write(32'h0C, (32'd200 << 16) | 32'd300);
        frame_pulse();
        show_pixel(55, 250, 12'h00F, "box_empty_a");
        show_pixel(55, 300, 12'h00F, "box_empty_b");

        // Blanking
        display_enable = 1'b0; step(); step();
        check_val("blank_de", {20'd0, red, green, blue}, 32'd0);
        display_enable = 1'b1; n_blank = 1'b0; step(); step();
        check_val("blank_nb", {20'd0, red, green, blue}, 32'd0);

        // Alignment: both changes appear together two edges later
        n_blank = 1'b1; display_enable = 1'b0; step(); step();
        display_enable = 1'b1; h_sync = 1'b0;
        step();
        check_val("align_hs_n1", {31'd0, h_sync_o}, 32'd1);
        check_val("align_de_n1", {31'd0, de_o}, 32'd0);
        step();
        check_val("align_hs_n2", {31'd0, h_sync_o}, 32'd0);
        check_val("align_rgb_n2", {20'd0, red, green, blue}, 32'h00F);
        h_sync = 1'b1;

        // Write on a frame-start edge applies one frame later
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h08; dat = 32'h0A0; v_sync = 1'b0;
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; v_sync = 1'b1;
        step();
        show_pixel(55, 250, 12'h00F, "collide_old");
        frame_pulse();
        show_pixel(55, 250, 12'h0A0, "collide_new");

        // FRAME read on its increment edge returns the old count
        wb_read(32'h14, f0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14; v_sync = 1'b0;
        step();
        check_val("frame_same_cycle", dout, f0);
        cyc = 1'b0; stb = 1'b0; v_sync = 1'b1;
        step();
        wb_read(32'h14, rdv);
        check_val("frame_incr", rdv, f0 + 32'd1);

        // Mid-line reset
        show_pixel(55, 250, 12'h0A0, "pre_reset");
        rst = 1'b1; h_sync = 1'b0;
        step();
        rst = 1'b0; h_sync = 1'b1;
        check_val("midreset_rgb", {20'd0, red, green, blue}, 32'd0);
        check_val("midreset_hs", {31'd0, h_sync_o}, 32'd1);
        wb_read(32'h14, rdv);  check_val("midreset_frame", rdv, 32'd0);
        wb_read(32'h08, rdv);  check_val("midreset_bg", rdv, 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            cyc = $urandom_range(0, 1) == 1;
            stb = $urandom_range(0, 1) == 1;
            we = $urandom_range(0, 1) == 1;
            adr = $urandom;
            dat = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h01FF_01FF);
            row = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 511));
            column = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1023));
            display_enable = $urandom_range(0, 7) != 0;
            n_blank = $urandom_range(0, 7) != 0;
            n_sync = $urandom_range(0, 1) == 1;
            h_sync = $urandom_range(0, 3) != 0;
            v_sync = $urandom_range(0, 15) != 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
